// File: rtl/frame_readout_buffer.sv
// Frame FIFO between the serial frame decoder and the MCU parallel bus; the head frame is read byte-wise.
// Optional per-frame timestamps are compiled in when FRAME_TIMESTAMP_EN is defined.
module frame_readout_buffer #(
    parameter int FRAME_BYTES = 12,
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 4,
    parameter int TS_W        = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [8*FRAME_BYTES-1:0] frame_in,
    input  logic                     frame_valid,
    input  logic                     rx_enable,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     pop,
    input  logic                     clr_status,
    output logic [7:0]               parallel_out,
    output logic                     frame_ready,
    output logic                     overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int NUM_ADDR = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(NUM_ADDR - 1);
    localparam logic [ADDR_W-1:0] ADDR_DROP   = ADDR_W'(NUM_ADDR - 2);
    localparam logic [ADDR_W-1:0] ADDR_TS_HI  = ADDR_W'(NUM_ADDR - 3);
    localparam logic [ADDR_W-1:0] ADDR_TS_LO  = ADDR_W'(NUM_ADDR - 4);

    logic [8*FRAME_BYTES-1:0] frame_mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_reg;
    logic [PTR_W-1:0]         rd_ptr_reg;
    logic [LVL_W-1:0]         level_reg;
    logic [LVL_W-1:0]         level_next;
    logic                     overflow_reg;
    logic [7:0]               drop_cnt_reg;
    logic                     frame_ready_reg;
    logic [7:0]               parallel_out_reg;
    logic [7:0]               read_next;

    logic push;
    logic full;
    logic empty;
    logic do_pop;
    logic do_push;
    logic drop;

    assign push    = frame_valid & rx_enable;
    assign full    = (level_reg == LVL_W'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    always_comb begin
        level_next = level_reg;
        case ({do_push, do_pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            frame_mem[wr_ptr_reg] <= frame_in;
        end
    end

    logic [TS_W-1:0] head_ts;
`ifdef FRAME_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt_reg;
    logic [TS_W-1:0] ts_mem [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_cnt_reg <= '0;
        end else begin
            ts_cnt_reg <= ts_cnt_reg + TS_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            ts_mem[wr_ptr_reg] <= ts_cnt_reg;
        end
    end

    assign head_ts = ts_mem[rd_ptr_reg];
`else
    assign head_ts = '0;
`endif

    // Head frame spread over the whole address space; bytes past the frame read as zero.
    logic [8*FRAME_BYTES-1:0] head_frame;
    logic [7:0]               head_bytes [NUM_ADDR];
    assign head_frame = frame_mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < NUM_ADDR; gi++) begin : g_head_bytes
            if (gi < FRAME_BYTES) begin : g_data
                assign head_bytes[gi] = head_frame[8*gi +: 8];
            end else begin : g_zero
                assign head_bytes[gi] = 8'h00;
            end
        end
    endgenerate

    logic [3:0] level_ext;
    assign level_ext = 4'(level_reg);

    always_comb begin
        read_next = 8'h00;
        case (address)
            ADDR_STATUS: read_next = {4'b0000, overflow_reg, level_ext[2:0]};
            ADDR_DROP:   read_next = drop_cnt_reg;
            ADDR_TS_HI:  read_next = empty ? 8'h00 : head_ts[15:8];
            ADDR_TS_LO:  read_next = empty ? 8'h00 : head_ts[7:0];
            default:     read_next = empty ? 8'h00 : head_bytes[address];
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            level_reg        <= '0;
            frame_ready_reg  <= 1'b0;
            overflow_reg     <= 1'b0;
            drop_cnt_reg     <= 8'h00;
            parallel_out_reg <= 8'h00;
        end else begin
            parallel_out_reg <= read_next;
            level_reg        <= level_next;
            frame_ready_reg  <= (level_next != '0);
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            // A drop overrides a simultaneous clear: the dropped frame is the first new event.
            if (drop) begin
                overflow_reg <= 1'b1;
                if (clr_status) begin
                    drop_cnt_reg <= 8'h01;
                end else if (drop_cnt_reg != 8'hFF) begin
                    drop_cnt_reg <= drop_cnt_reg + 8'h01;
                end
            end else if (clr_status) begin
                overflow_reg <= 1'b0;
                drop_cnt_reg <= 8'h00;
            end
        end
    end

    assign parallel_out = parallel_out_reg;
    assign frame_ready  = frame_ready_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_frame_readout_buffer.sv
// Bench for frame_readout_buffer: queue-based reference model compared every cycle plus directed literal checks.
// Timestamp checks are included when FRAME_TIMESTAMP_EN is defined.
module tb_frame_readout_buffer;
    localparam int FB     = 12;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 4;
    localparam int A      = 15;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [8*FB-1:0] frame_in = '0;
    logic            frame_valid = 1'b0;
    logic            rx_enable = 1'b1;
    logic [ADDR_W-1:0] address = '0;
    logic            pop = 1'b0;
    logic            clr_status = 1'b0;
    logic [7:0]      parallel_out;
    logic            frame_ready;
    logic            overflow;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clock = ~clock;

    frame_readout_buffer #(
        .FRAME_BYTES(FB),
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W),
        .TS_W(16)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .frame_in(frame_in),
        .frame_valid(frame_valid),
        .rx_enable(rx_enable),
        .address(address),
        .pop(pop),
        .clr_status(clr_status),
        .parallel_out(parallel_out),
        .frame_ready(frame_ready),
        .overflow(overflow)
    );

    // Reference model: a frame queue plus status, read out through the address map.
    logic [8*FB-1:0] mq [$];
    logic [15:0]     mts [$];
    logic            m_ovf;
    logic [7:0]      m_drop;
    logic [15:0]     m_cnt;
    logic [7:0]      m_out;

    function automatic logic [7:0] model_byte(input logic [ADDR_W-1:0] a);
        logic [8*FB-1:0] f;
        logic [15:0]     ts;
        int              lv;
        logic [3:0]      l4;
        int              ai;
        ai = int'(a);
        lv = mq.size();
        l4 = lv[3:0];
        if (ai < FB) begin
            if (lv == 0) return 8'h00;
            f = mq[0];
            return f[8*ai +: 8];
        end
        if (ai == A)   return {4'b0000, m_ovf, l4[2:0]};
        if (ai == A-1) return m_drop;
`ifdef FRAME_TIMESTAMP_EN
        if (lv != 0) begin
            ts = mts[0];
            if (ai == A-2) return ts[15:8];
            if (ai == A-3) return ts[7:0];
        end
`else
        ts = 16'h0000;
        if (ai == A-2 || ai == A-3) return ts[7:0];
`endif
        return 8'h00;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            mts.delete();
            m_ovf  = 1'b0;
            m_drop = 8'h00;
            m_cnt  = 16'h0000;
            m_out  = 8'h00;
        end else begin
            bit pushv, popv, dropv;
            m_out = model_byte(address);
            pushv = frame_valid && rx_enable;
            popv  = pop && (mq.size() > 0);
            dropv = 1'b0;
            if (popv) begin
                void'(mq.pop_front());
                void'(mts.pop_front());
            end
            if (pushv) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(frame_in);
                    mts.push_back(m_cnt);
                end else begin
                    dropv = 1'b1;
                end
            end
            if (dropv) begin
                m_ovf  = 1'b1;
                m_drop = clr_status ? 8'h01 : ((m_drop == 8'hFF) ? 8'hFF : m_drop + 8'h01);
            end else if (clr_status) begin
                m_ovf  = 1'b0;
                m_drop = 8'h00;
            end
            m_cnt = m_cnt + 16'h0001;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("model parallel_out", {8'h00, parallel_out}, {8'h00, m_out});
            check("model frame_ready", {15'h0, frame_ready}, {15'h0, (mq.size() != 0)});
            check("model overflow", {15'h0, overflow}, {15'h0, m_ovf});
        end
    end

    function automatic logic [8*FB-1:0] make_frame(input logic [7:0] base);
        logic [8*FB-1:0] f;
        for (int i = 0; i < FB; i++) f[8*i +: 8] = base + 8'(i);
        return f;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] base, input bit with_pop, input bit with_clr);
        frame_in    = make_frame(base);
        frame_valid = 1'b1;
        pop         = with_pop;
        clr_status  = with_clr;
        step();
        frame_valid = 1'b0;
        pop         = 1'b0;
        clr_status  = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    task automatic read(input logic [ADDR_W-1:0] a, output logic [7:0] v);
        address = a;
        step();
        v = parallel_out;
    endtask

    logic [7:0] rv;
    logic [7:0] ts_a_hi, ts_a_lo, ts_b_hi, ts_b_lo;

    initial begin
        step();
        step();
        chk_en = 1'b1;
        check("reset parallel_out", {8'h00, parallel_out}, 16'h0000);
        check("reset frame_ready", {15'h0, frame_ready}, 16'h0000);
        check("reset overflow", {15'h0, overflow}, 16'h0000);
        reset_n = 1'b1;
        step();

        // 1: single frame readout
        push_frame(8'h01, 1'b0, 1'b0);
        check("t1 frame_ready after push", {15'h0, frame_ready}, 16'h0001);
        read(4'd0, rv);  check("t1 byte0", {8'h00, rv}, 16'h0001);
        read(4'd11, rv); check("t1 byte11", {8'h00, rv}, 16'h000C);
        read(4'd15, rv); check("t1 status", {8'h00, rv}, 16'h0001);

        // 2: overflow on the fifth push
        push_frame(8'h11, 1'b0, 1'b0);
        push_frame(8'h21, 1'b0, 1'b0);
        push_frame(8'h31, 1'b0, 1'b0);
        push_frame(8'h41, 1'b0, 1'b0);
        check("t2 overflow", {15'h0, overflow}, 16'h0001);
        read(4'd14, rv); check("t2 drop_cnt", {8'h00, rv}, 16'h0001);
        read(4'd15, rv); check("t2 status full", {8'h00, rv}, 16'h000C);
        read(4'd0, rv);  check("t2 pop order 1", {8'h00, rv}, 16'h0001);
        do_pop();
        read(4'd0, rv);  check("t2 pop order 2", {8'h00, rv}, 16'h0011);
        do_pop();
        read(4'd0, rv);  check("t2 pop order 3", {8'h00, rv}, 16'h0021);
        do_pop();
        read(4'd0, rv);  check("t2 pop order 4", {8'h00, rv}, 16'h0031);
        do_pop();
        read(4'd15, rv); check("t2 status empty", {8'h00, rv}, 16'h0008);
        read(4'd0, rv);  check("t2 empty byte0", {8'h00, rv}, 16'h0000);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        read(4'd15, rv); check("t2 status cleared", {8'h00, rv}, 16'h0000);

        // 3: push+pop while full
        push_frame(8'h51, 1'b0, 1'b0);
        push_frame(8'h61, 1'b0, 1'b0);
        push_frame(8'h71, 1'b0, 1'b0);
        push_frame(8'h81, 1'b0, 1'b0);
        push_frame(8'h91, 1'b1, 1'b0);
        read(4'd15, rv); check("t3 status", {8'h00, rv}, 16'h0004);
        read(4'd14, rv); check("t3 drop_cnt", {8'h00, rv}, 16'h0000);
        read(4'd0, rv);  check("t3 head", {8'h00, rv}, 16'h0061);
        do_pop();
        do_pop();
        do_pop();
        read(4'd5, rv);  check("t3 newest byte5", {8'h00, rv}, 16'h0096);
        do_pop();

        // 4: rx gating
        rx_enable = 1'b0;
        for (int i = 0; i < 3; i++) push_frame(8'hE0 + 8'(i), 1'b0, 1'b0);
        rx_enable = 1'b1;
        read(4'd15, rv); check("t4 status", {8'h00, rv}, 16'h0000);
        read(4'd14, rv); check("t4 drop_cnt", {8'h00, rv}, 16'h0000);

        // 5: pop while empty, clear coinciding with drop
        do_pop();
        read(4'd15, rv); check("t5 empty pop status", {8'h00, rv}, 16'h0000);
        push_frame(8'hA1, 1'b0, 1'b0);
        push_frame(8'hB1, 1'b0, 1'b0);
        push_frame(8'hC1, 1'b0, 1'b0);
        push_frame(8'hD1, 1'b0, 1'b0);
        push_frame(8'hF1, 1'b0, 1'b1);
        check("t5 overflow", {15'h0, overflow}, 16'h0001);
        read(4'd14, rv); check("t5 drop_cnt", {8'h00, rv}, 16'h0001);
        read(4'd15, rv); check("t5 status", {8'h00, rv}, 16'h000C);

        // 6: reset mid-read with 3 frames queued
        do_pop();
        address = 4'd0;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("t6 in-reset parallel_out", {8'h00, parallel_out}, 16'h0000);
        check("t6 in-reset frame_ready", {15'h0, frame_ready}, 16'h0000);
        step();
        reset_n = 1'b1;
        step();
        read(4'd15, rv); check("t6 status after reset", {8'h00, rv}, 16'h0000);
        read(4'd0, rv);  check("t6 byte0 after reset", {8'h00, rv}, 16'h0000);

`ifdef FRAME_TIMESTAMP_EN
        push_frame(8'h02, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step();
        push_frame(8'h03, 1'b0, 1'b0);
        read(4'd13, ts_a_hi);
        read(4'd12, ts_a_lo);
        do_pop();
        read(4'd13, ts_b_hi);
        read(4'd12, ts_b_lo);
        check("ts delta", {ts_b_hi, ts_b_lo} - {ts_a_hi, ts_a_lo}, 16'd10);
`else
        push_frame(8'h02, 1'b0, 1'b0);
        read(4'd13, ts_a_hi);
        read(4'd12, ts_a_lo);
        check("ts disabled", {ts_a_hi, ts_a_lo}, 16'h0000);
        ts_b_hi = 8'h00;
        ts_b_lo = 8'h00;
`endif

        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
